// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_pkg
// Description : Shared types and constants for the CPU bus bridge. Holds the
//               bridge FSM state encoding, the RW / MemIO request encodings,
//               the default width constants and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

    // Default configuration constants
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_MEM_DEPTH = 256;
    localparam int DEF_IO_PORTS  = 4;
    localparam int DEF_MEM_WAIT  = 1;

    // Wait counter is wide enough for MEM_WAIT in 0..15
    localparam int WAIT_CNT_W = 4;

    // Request encodings
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
    localparam logic SEL_MEM  = 1'b0;
    localparam logic SEL_IO   = 1'b1;

    // Bridge FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Index width for an n-entry table; never narrower than one bit so that
    // single-entry tables still yield a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cpu_bus_pkg
`default_nettype wire

// File: rtl/bridge_ram.sv
`default_nettype none
// ============================================================================
// Module      : bridge_ram
// Description : Single-port synchronous RAM, DATA_W x DEPTH, with a write
//               enable and a registered read port (read-before-write).
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
//
// Ports
//   clk    in   1       rising-edge clock
//   we     in   1       write enable
//   addr   in   AW      word address
//   wdata  in   DATA_W  write data
//   rdata  out  DATA_W  registered read data (previous contents on write)
// ============================================================================
module bridge_ram
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_MEM_DEPTH,
    parameter int AW     = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule : bridge_ram
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_bridge
// Description : Bridges a simple CPU request interface (en/ready handshake)
//               onto an internal word memory and a bank of IO registers.
//               Memory accesses take MEM_WAIT extra cycles, IO accesses
//               complete in one cycle. Each request ends with a one-cycle
//               rvalid pulse; data_read holds the most recent read result.
//
// Optional feature macro : CPU_BUS_ERR_EN
//   Defined   -> err port present; out-of-range addresses complete with
//                err = 1 during the response cycle, no write, data_read = 0.
//   Undefined -> no err port; out-of-range addresses alias onto low bits.
//
// Revision    : 1.0 - initial release
//
// Ports
//   clk         in   1                  rising-edge clock
//   rst_n       in   1                  synchronous active-low reset
//   en          in   1                  request valid
//   ready       out  1                  bridge idle (accept on en && ready)
//   RW          in   1                  0 = read, 1 = write
//   MemIO       in   1                  0 = memory, 1 = IO
//   addr        in   ADDR_W             word address
//   data_write  in   DATA_W             write data
//   data_read   out  DATA_W             read data, valid with rvalid
//   rvalid      out  1                  completion pulse
//   io_in       in   IO_PORTS*DATA_W    IO input words, port k at k*DATA_W
//   io_out      out  IO_PORTS*DATA_W    registered IO output words
//   err         out  1                  access error (CPU_BUS_ERR_EN only)
// ============================================================================
module cpu_bus_bridge
    import cpu_bus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int IO_PORTS  = DEF_IO_PORTS,
    parameter int MEM_WAIT  = DEF_MEM_WAIT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    output logic                       ready,
    input  logic                       RW,
    input  logic                       MemIO,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          data_write,
    output logic [DATA_W-1:0]          data_read,
    output logic                       rvalid,
    input  logic [IO_PORTS*DATA_W-1:0] io_in,
    output logic [IO_PORTS*DATA_W-1:0] io_out
`ifdef CPU_BUS_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int MEM_AW    = idx_width(MEM_DEPTH);
    localparam int IO_AW     = idx_width(IO_PORTS);
    localparam int MEM_SHIFT = $clog2(MEM_DEPTH);
    localparam int IO_SHIFT  = $clog2(IO_PORTS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
        (MEM_WAIT > 0) ? WAIT_CNT_W'(MEM_WAIT - 1) : '0;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                  state_q;
    state_t                  state_d;
    logic                    go_resp;
    logic                    enter_wait;

    logic                    rw_q;
    logic                    memio_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    err_q;
    logic [DATA_W-1:0]       data_hold;

    logic                    cur_rw;
    logic                    cur_memio;
    logic [ADDR_W-1:0]       cur_addr;
    logic [DATA_W-1:0]       cur_wdata;
    logic [IO_AW-1:0]        io_idx;
    logic                    mem_addr_ok;
    logic                    io_addr_ok;
    logic                    addr_ok;

    logic                    ram_we;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    mem_read_q;

    // ------------------------------------------------------------------
    // Effective request: live inputs while idle (the accept cycle), the
    // latched copy afterwards. This lets a zero-wait memory access and
    // IO accesses commit on the accept edge itself.
    // ------------------------------------------------------------------
    always_comb begin
        cur_rw    = rw_q;
        cur_memio = memio_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            cur_rw    = RW;
            cur_memio = MemIO;
            cur_addr  = addr;
            cur_wdata = data_write;
        end
    end

    generate
        if (IO_PORTS > 1) begin : g_io_idx_multi
            assign io_idx = cur_addr[IO_AW-1:0];
        end else begin : g_io_idx_single
            assign io_idx = '0;
        end
    endgenerate

    // Range checks: any address bit above the table index makes the access
    // out of range.
    assign mem_addr_ok = ((cur_addr >> MEM_SHIFT) == '0);
    assign io_addr_ok  = ((cur_addr >> IO_SHIFT) == '0);

`ifdef CPU_BUS_ERR_EN
    assign addr_ok = (cur_memio == SEL_IO) ? io_addr_ok : mem_addr_ok;
`else
    // Without error reporting, high address bits simply alias.
    logic unused_range;
    assign unused_range = mem_addr_ok ^ io_addr_ok;
    assign addr_ok      = 1'b1;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        go_resp    = 1'b0;
        enter_wait = 1'b0;
        ready      = 1'b0;
        rvalid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (en) begin
                    if ((MemIO == SEL_IO) || (MEM_WAIT == 0)) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        enter_wait = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end
            end
            ST_RESP: begin
                rvalid  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory. The write is issued on the edge entering RESP; gating with
    // rst_n guarantees a reset on that edge aborts the write.
    // ------------------------------------------------------------------
    assign ram_we = rst_n && go_resp && addr_ok &&
                    (cur_rw == RW_WRITE) && (cur_memio == SEL_MEM);

    bridge_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (MEM_AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .addr   (cur_addr[MEM_AW-1:0]),
        .wdata  (cur_wdata),
        .rdata  (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Request latch, wait counter, IO registers and read-data holding
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q      <= RW_READ;
            memio_q   <= SEL_MEM;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
            data_hold <= '0;
            io_out    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && en) begin
                rw_q    <= RW;
                memio_q <= MemIO;
                addr_q  <= addr;
                wdata_q <= data_write;
            end

            if (enter_wait) begin
                wait_cnt <= WAIT_INIT;
            end else if ((state_q == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            // Commit point: IO writes land here and IO reads sample io_in.
            if (go_resp) begin
                err_q <= !addr_ok;
                if (!addr_ok) begin
                    data_hold <= '0;
                end else if (cur_memio == SEL_IO) begin
                    if (cur_rw == RW_WRITE) begin
                        io_out[io_idx*DATA_W +: DATA_W] <= cur_wdata;
                    end else begin
                        data_hold <= io_in[io_idx*DATA_W +: DATA_W];
                    end
                end
            end

            // RAM read data only appears during RESP; keep it afterwards.
            if ((state_q == ST_RESP) && mem_read_q) begin
                data_hold <= ram_rdata;
            end
        end
    end

    assign mem_read_q = (rw_q == RW_READ) && (memio_q == SEL_MEM) && !err_q;

    // During a memory-read response the RAM output is forwarded directly;
    // otherwise the held value is presented.
    assign data_read = ((state_q == ST_RESP) && mem_read_q) ? ram_rdata : data_hold;

`ifdef CPU_BUS_ERR_EN
    assign err = (state_q == ST_RESP) && err_q;
`endif

endmodule : cpu_bus_bridge
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_bridge
// Description : Self-checking bench for cpu_bus_bridge. The main instance
//               uses MEM_WAIT = 1; two extra instances (MEM_WAIT = 0 and 3)
//               share its inputs for latency checks. Expected completions
//               come from a small behavioural model and travel through a
//               scoreboard queue. Honours CPU_BUS_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_bridge;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int IO_N  = 4;
    localparam int MW    = 1;

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              RW;
    logic              MemIO;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data_write;
    logic [IO_N*DW-1:0] io_in;

    logic              ready, rvalid, err_m;
    logic [DW-1:0]     data_read;
    logic [IO_N*DW-1:0] io_out;
    logic              ready0, rvalid0, err0;
    logic [DW-1:0]     data_read0;
    logic [IO_N*DW-1:0] io_out0;
    logic              ready3, rvalid3, err3;
    logic [DW-1:0]     data_read3;
    logic [IO_N*DW-1:0] io_out3;

    always #5 clk = ~clk;

    cpu_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .IO_PORTS(IO_N), .MEM_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ready(ready), .RW(RW), .MemIO(MemIO),
        .addr(addr), .data_write(data_write), .data_read(data_read), .rvalid(rvalid),
        .io_in(io_in), .io_out(io_out)
`ifdef CPU_BUS_ERR_EN
        , .err(err_m)
`endif
    );

    cpu_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .IO_PORTS(IO_N), .MEM_WAIT(0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .en(en), .ready(ready0), .RW(RW), .MemIO(MemIO),
        .addr(addr), .data_write(data_write), .data_read(data_read0), .rvalid(rvalid0),
        .io_in(io_in), .io_out(io_out0)
`ifdef CPU_BUS_ERR_EN
        , .err(err0)
`endif
    );

    cpu_bus_bridge #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .IO_PORTS(IO_N), .MEM_WAIT(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .en(en), .ready(ready3), .RW(RW), .MemIO(MemIO),
        .addr(addr), .data_write(data_write), .data_read(data_read3), .rvalid(rvalid3),
        .io_in(io_in), .io_out(io_out3)
`ifdef CPU_BUS_ERR_EN
        , .err(err3)
`endif
    );

`ifndef CPU_BUS_ERR_EN
    assign err_m = 1'b0;
    assign err0  = 1'b0;
    assign err3  = 1'b0;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         sb[$];
    logic [15:0]  m_mem [DEPTH];
    logic [IO_N*DW-1:0] m_io;
    logic [15:0]  m_last;

    int           lat;
    logic [15:0]  got_d;
    logic         got_e;
    exp_t         ex;

    // Reference model: returns the expected completion and updates state.
    task automatic model_req(input logic rw, input logic mio, input logic [15:0] a,
                             input logic [15:0] wd, output exp_t x);
        logic bad;
        bad = 1'b0;
`ifdef CPU_BUS_ERR_EN
        bad = mio ? (int'(a) >= IO_N) : (int'(a) >= DEPTH);
`endif
        x.lat = mio ? 1 : MW + 1;
        x.err = bad;
        if (bad) begin
            m_last = 16'h0000;
        end else if (!rw) begin
            m_last = mio ? io_in[(int'(a) % IO_N)*DW +: DW] : m_mem[int'(a) % DEPTH];
        end else if (mio) begin
            m_io[(int'(a) % IO_N)*DW +: DW] = wd;
        end else begin
            m_mem[int'(a) % DEPTH] = wd;
        end
        x.data = m_last;
    endtask

    // Wait for ready, present one request for one accept edge, scramble after.
    task automatic issue(input logic rw, input logic mio, input logic [15:0] a, input logic [15:0] wd);
        exp_t x;
        for (int b = 0; b < 50 && !ready; b++) begin
            @(posedge clk); #1;
        end
        en = 1'b1; RW = rw; MemIO = mio; addr = a; data_write = wd;
        model_req(rw, mio, a, wd, x);
        sb.push_back(x);
        @(posedge clk); #1;
        en = 1'b0; RW = ~rw; MemIO = ~mio; addr = 16'h0077; data_write = 16'hDEAD;
    endtask

    // Called #1 after the accept edge; cycle 1 is the cycle right after it.
    task automatic await_resp(output int l, output logic [15:0] d, output logic e);
        l = 0; d = '0; e = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (rvalid) begin
                l = n; d = data_read; e = err_m;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        en = 1'b0; RW = 1'b0; MemIO = 1'b0; addr = '0; data_write = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", ready); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b want 0", rvalid); end
        n_tests++; if (data_read !== 16'h0) begin n_fail++; $display("FAIL reset_data_read: got %h want 0000", data_read); end
        n_tests++; if (io_out !== '0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0", io_out); end
        rst_n = 1'b1;
        m_last = '0; m_io = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_mem();
        logic [15:0] pa [4];
        logic [15:0] pd [4];
        pa[0] = 16'h0010; pa[1] = 16'h00FF; pa[2] = 16'h0080; pa[3] = 16'h0001;
        pd[0] = 16'h5A5A; pd[1] = 16'h0001; pd[2] = 16'hA5A5; pd[3] = 16'h8000;
        issue(1'b1, 1'b0, 16'h0000, 16'hFFFF);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL mem_wr_latency: got %0d want 2", lat); end
        n_tests++; if (got_d !== ex.data) begin n_fail++; $display("FAIL mem_wr_data_hold: got %h want %h", got_d, ex.data); end
        @(posedge clk); #1;
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mem_rvalid_pulse: got %0b want 0", rvalid); end
        issue(1'b0, 1'b0, 16'h0000, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL mem_rd_latency: got %0d want 2", lat); end
        n_tests++; if (got_d !== 16'hFFFF) begin n_fail++; $display("FAIL mem_rd_ffff: got %h want ffff", got_d); end
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, pa[i], pd[i]);
            await_resp(lat, got_d, got_e); ex = sb.pop_front();
            issue(1'b0, 1'b0, pa[i], 16'h0000);
            await_resp(lat, got_d, got_e); ex = sb.pop_front();
            n_tests++; if (got_d !== ex.data || lat !== ex.lat) begin
                n_fail++; $display("FAIL mem_pattern_%0d: got %h/%0d want %h/%0d", i, got_d, lat, ex.data, ex.lat);
            end
        end
        // 0x0110 aliases onto 0x0010 unless errors are reported
        issue(1'b0, 1'b0, 16'h0110, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (got_d !== ex.data || got_e !== ex.err) begin
            n_fail++; $display("FAIL mem_alias: got %h err %0b want %h err %0b", got_d, got_e, ex.data, ex.err);
        end
    endtask

    task automatic test_io();
        io_in = {16'hC0DE, 16'h2222, 16'hBEEF, 16'h1111};
        issue(1'b1, 1'b1, 16'h0002, 16'h1234);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL io_wr_latency: got %0d want 1", lat); end
        n_tests++; if (io_out[47:32] !== 16'h1234) begin n_fail++; $display("FAIL io_out_port2: got %h want 1234", io_out[47:32]); end
        n_tests++; if (io_out !== m_io) begin n_fail++; $display("FAIL io_out_all: got %h want %h", io_out, m_io); end
        n_tests++; if (got_d !== ex.data) begin n_fail++; $display("FAIL io_wr_data_hold: got %h want %h", got_d, ex.data); end
        issue(1'b0, 1'b1, 16'h0001, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL io_rd_latency: got %0d want 1", lat); end
        n_tests++; if (got_d !== 16'hBEEF) begin n_fail++; $display("FAIL io_rd_beef: got %h want beef", got_d); end
        // Write completion must leave the last read value in place
        issue(1'b1, 1'b1, 16'h0000, 16'h5555);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (got_d !== 16'hBEEF || io_out !== m_io) begin
            n_fail++; $display("FAIL io_wr_keep_read: got %h io %h want beef io %h", got_d, io_out, m_io);
        end
        issue(1'b0, 1'b1, 16'h0007, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (got_d !== ex.data || got_e !== ex.err) begin
            n_fail++; $display("FAIL io_alias: got %h err %0b want %h err %0b", got_d, got_e, ex.data, ex.err);
        end
    endtask

    task automatic test_back_to_back();
        logic        rws [3];
        logic        mios[3];
        logic [15:0] as  [3];
        logic [15:0] wds [3];
        int acc = 0, pulses = 0, busy_bad = 0, busy_cyc = 0, busy_exp = 0;
        logic take;
        exp_t x;
        rws[0] = 1'b1; mios[0] = 1'b0; as[0] = 16'h0042; wds[0] = 16'h1111;
        rws[1] = 1'b0; mios[1] = 1'b1; as[1] = 16'h0003; wds[1] = 16'h0000;
        rws[2] = 1'b0; mios[2] = 1'b0; as[2] = 16'h0042; wds[2] = 16'h0000;
        for (int b = 0; b < 50 && !ready; b++) begin @(posedge clk); #1; end
        en = 1'b1; RW = rws[0]; MemIO = mios[0]; addr = as[0]; data_write = wds[0];
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            take = ready && en;
            if (take) begin
                model_req(RW, MemIO, addr, data_write, x);
                sb.push_back(x);
                busy_exp += x.lat;
            end
            @(posedge clk); #1;
            if (take) begin
                acc++;
                if (acc < 3) begin
                    RW = rws[acc]; MemIO = mios[acc]; addr = as[acc]; data_write = wds[acc];
                end else begin
                    en = 1'b0;
                end
            end
            if (!ready) busy_cyc++;
            if (rvalid) begin
                pulses++;
                if (ready) busy_bad++;
                if (sb.size() > 0) begin
                    x = sb.pop_front();
                    n_tests++; if (data_read !== x.data) begin
                        n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", pulses, data_read, x.data);
                    end
                end
            end
        end
        n_tests++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 3", acc); end
        n_tests++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        n_tests++; if (busy_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_in_resp: got %0d want 0", busy_bad); end
        n_tests++; if (busy_cyc !== busy_exp) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want %0d", busy_cyc, busy_exp); end
        sb.delete();
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        issue(1'b1, 1'b0, 16'h0005, 16'h1357);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        issue(1'b1, 1'b1, 16'h0003, 16'h7777);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        for (int b = 0; b < 50 && !ready; b++) begin @(posedge clk); #1; end
        en = 1'b1; RW = 1'b1; MemIO = 1'b0; addr = 16'h0005; data_write = 16'hAAAA;
        @(posedge clk); #1;
        en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %0b want 1", ready); end
        n_tests++; if (data_read !== 16'h0) begin n_fail++; $display("FAIL abort_data_read: got %h want 0000", data_read); end
        n_tests++; if (io_out !== '0) begin n_fail++; $display("FAIL abort_io_out: got %h want 0", io_out); end
        for (int c = 0; c < 5; c++) begin
            if (rvalid) seen++;
            @(posedge clk); #1;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_rvalid: got %0d pulses want 0", seen); end
        m_last = '0; m_io = '0;
        issue(1'b0, 1'b0, 16'h0005, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (got_d !== 16'h1357) begin n_fail++; $display("FAIL abort_mem5: got %h want 1357", got_d); end
    endtask

    task automatic test_err();
        issue(1'b1, 1'b0, 16'h0000, 16'h0F0F);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        issue(1'b1, 1'b0, 16'h0100, 16'hCAFE);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL err_wr_latency: got %0d want 2", lat); end
        n_tests++; if (got_e !== ex.err || got_d !== ex.data) begin
            n_fail++; $display("FAIL err_wr_flag: got err %0b data %h want err %0b data %h", got_e, got_d, ex.err, ex.data);
        end
        @(posedge clk); #1;
        n_tests++; if (err_m !== 1'b0) begin n_fail++; $display("FAIL err_after_resp: got %0b want 0", err_m); end
        issue(1'b0, 1'b0, 16'h0000, 16'h0000);
        await_resp(lat, got_d, got_e); ex = sb.pop_front();
`ifdef CPU_BUS_ERR_EN
        n_tests++; if (got_d !== 16'h0F0F) begin n_fail++; $display("FAIL err_mem0_kept: got %h want 0f0f", got_d); end
`else
        n_tests++; if (got_d !== 16'hCAFE) begin n_fail++; $display("FAIL alias_mem0_written: got %h want cafe", got_d); end
`endif
        n_tests++; if (got_e !== 1'b0) begin n_fail++; $display("FAIL err_rd_flag: got %0b want 0", got_e); end
    endtask

    task automatic test_latency();
        int l0 = 0, l1 = 0, l3 = 0;
        logic [15:0] d0 = '0, d1 = '0, d3 = '0;
        for (int b = 0; b < 50 && !(ready && ready0 && ready3); b++) begin @(posedge clk); #1; end
        en = 1'b1; RW = 1'b1; MemIO = 1'b0; addr = 16'h0020; data_write = 16'h6789;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        en = 1'b1; RW = 1'b0; MemIO = 1'b0; addr = 16'h0020; data_write = 16'h0000;
        @(posedge clk); #1;
        en = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (rvalid0 && l0 == 0) begin l0 = n; d0 = data_read0; end
            if (rvalid  && l1 == 0) begin l1 = n; d1 = data_read;  end
            if (rvalid3 && l3 == 0) begin l3 = n; d3 = data_read3; end
            @(posedge clk); #1;
        end
        n_tests++; if (l0 !== 1) begin n_fail++; $display("FAIL lat_wait0: got %0d want 1", l0); end
        n_tests++; if (l1 !== 2) begin n_fail++; $display("FAIL lat_wait1: got %0d want 2", l1); end
        n_tests++; if (l3 !== 4) begin n_fail++; $display("FAIL lat_wait3: got %0d want 4", l3); end
        n_tests++; if (d0 !== 16'h6789 || d1 !== 16'h6789 || d3 !== 16'h6789) begin
            n_fail++; $display("FAIL lat_data: got %h %h %h want 6789", d0, d1, d3);
        end
    endtask

    initial begin
        io_in = '0;
        test_reset();
        test_mem();
        test_io();
        test_back_to_back();
        test_reset_abort();
        test_err();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cpu_bus_bridge
`default_nettype wire

// File: doc/cpu_bus_bridge.md
CPU_BUS_BRIDGE -- requirements
Module: cpu_bus_bridge

Interface
REQ-001 Parameter DATA_W, 16, data word width.
REQ-002 Parameter ADDR_W, 16, address width.
REQ-003 Parameter MEM_DEPTH, 256, memory words (power of two, <= 2**ADDR_W).
REQ-004 Parameter IO_PORTS, 4, number of IO registers (power of two, >= 1).
REQ-005 Parameter MEM_WAIT, 1, extra wait cycles per memory access (0..15).
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 en  in  1  request valid.
REQ-010 ready  out  1  bridge idle, request accepted when en && ready at posedge.
REQ-011 RW  in  1  0 = read, 1 = write.
REQ-012 MemIO  in  1  0 = memory, 1 = IO.
REQ-013 addr  in  ADDR_W  word address.
REQ-014 data_write  in  DATA_W  write data.
REQ-015 data_read  out  DATA_W  read data, valid with rvalid.
REQ-016 rvalid  out  1  one-cycle completion pulse (reads and writes).
REQ-017 io_in  in  IO_PORTS*DATA_W  external IO input words, port k at [k*DATA_W +: DATA_W].
REQ-018 io_out  out  IO_PORTS*DATA_W  registered IO output words, same packing.
REQ-019 err  out  1  access-error flag (present only with CPU_BUS_ERR_EN).

Function
REQ-020 FSM states IDLE, WAIT, RESP; ready SHALL equal (state == IDLE).
REQ-021 On accept, RW, MemIO, addr, data_write SHALL be latched; later input changes ignored until next accept.
REQ-022 Memory access: IDLE -> WAIT for MEM_WAIT cycles -> RESP; MEM_WAIT = 0 goes IDLE -> RESP.
REQ-023 IO access: IDLE -> RESP.
REQ-024 rvalid high exactly during RESP: MEM_WAIT+1 cycles after accept edge for memory, 1 cycle for IO.
REQ-025 RESP -> IDLE unconditionally; ready high the cycle after rvalid, accepting back-to-back requests.
REQ-026 en while ready low SHALL be ignored, not queued.
REQ-027 Memory index = addr[log2(MEM_DEPTH)-1:0]; IO index = addr[log2(IO_PORTS)-1:0] (wrap/alias).
REQ-028 Memory/IO write committed at RESP edge; io_out[idx] updates from that edge.
REQ-029 Memory read returns stored word; IO read returns io_in[idx] sampled at entry to RESP.
REQ-030 data_read SHALL hold last read value; write completions leave it unchanged.

Reset
REQ-031 rst_n low at posedge: state IDLE, ready 1, rvalid 0, data_read 0, io_out all 0, wait counter 0, err 0.
REQ-032 Memory contents not reset; reset mid-transaction aborts it with no write committed and no rvalid.

Configuration
REQ-033 Macro CPU_BUS_ERR_EN defined: err port present; memory addr >= MEM_DEPTH or IO addr >= IO_PORTS completes with rvalid, err = 1 in RESP only, no write, data_read = 0.
REQ-034 Macro undefined: no err port, out-of-range addresses alias per REQ-027.

Structure
REQ-035 Package cpu_bus_pkg holds state enum, RW/MemIO encoding constants, default width constants.
REQ-036 Sub-module bridge_ram: single-port synchronous RAM, DATA_W x MEM_DEPTH, write enable, registered read.

Verification
REQ-037 Write 0xFFFF to mem addr 0x0000, then read it -> rvalid at cycle 2 after each accept (MEM_WAIT=1), data_read = 0xFFFF.
REQ-038 IO write 0x1234 to addr 2, then IO read addr 1 with io_in port1 = 0xBEEF -> io_out port2 = 0x1234, data_read = 0xBEEF, 1-cycle latency each.
REQ-039 en held high across 3 requests -> exactly 3 rvalid pulses, none during WAIT/RESP, ready low while busy.
REQ-040 rst_n low in WAIT of write 0xAAAA to addr 5 -> no rvalid, mem[5] unchanged, outputs at reset values.
REQ-041 With CPU_BUS_ERR_EN, write addr 0x0100 (MEM_DEPTH 256) -> err = 1 with rvalid, mem[0] unchanged; without macro -> mem[0] written.
REQ-042 MEM_WAIT = 0 and 3 builds -> memory read rvalid 1 and 4 cycles after accept.
